spi_regfile: RTL and testbench
==============================

SPI_REGFILE -- requirements
Module: spi_regfile

Interface
REQ-001 SHALL have parameter IDVALUE, default 8'hA5, the constant returned on reads of address 15.
REQ-002 SHALL have parameter CTRLRESET, default 64'h0, the reset image of control registers 0-7 (register n in bits 8n+7:8n).
REQ-003 SHALL have port clk  input  1  system clock; the block has one clock, and all logic is on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port spiclk  input  1  raw SPI SCLK (asynchronous to clk).
REQ-006 SHALL have port spiwrt  input  1  write-transaction indicator from the SPI slave (asynchronous).
REQ-007 SHALL have port spirdt  input  1  read-transaction indicator from the SPI slave (asynchronous).
REQ-008 SHALL have port spiaddr  input  4  register address from the SPI slave (quasi-static).
REQ-009 SHALL have port spiwrtdata  input  8  shifted write data from the SPI slave (quasi-static).
REQ-010 SHALL have port spirddata  output  8  read data presented to the SPI slave's parallel load input.
REQ-011 SHALL have port ctrl  output  64  control registers 0-7, flattened.
REQ-012 SHALL have port status  input  56  status bytes for addresses 8-14 (address a in bits 8(a-8)+7:8(a-8)).
REQ-013 SHALL have port wrstb  output  1  one-clk pulse marking a committed write.
REQ-014 SHALL have port rdstb  output  1  one-clk pulse marking the read-data capture.
REQ-015 SHALL have port evaddr  output  4  address of the last wrstb/rdstb event, valid while either strobe is high.

Function
REQ-016 SHALL synchronise spiclk through 2 flops and spiwrt/spirdt through 3 flops, so an SCLK edge is always seen before the wrt/rdt change it causes.
REQ-017 SHALL require f(clk) >= 4 x f(spiclk), with each SCLK phase >= 2 clk periods; behaviour is undefined otherwise.
REQ-018 SHALL increment a 4-bit edge counter, saturating at 15, on each synchronised spiclk rising edge seen while synchronised spiwrt is high.
REQ-019 SHALL clear the edge counter in the cycle after synchronised spiwrt rises.
REQ-020 SHALL, when synchronised spiwrt falls with edge count == 8, commit the write as follows: if spiaddr <= 7, load spiwrtdata into ctrl register spiaddr; in every case pulse wrstb for one cycle and set evaddr = spiaddr.
REQ-021 SHALL, when synchronised spiwrt falls with edge count != 8 (aborted or overrun transaction), discard the write with no register change and no wrstb.
REQ-022 SHALL ignore writes to addresses 8-15 apart from the wrstb pulse.
REQ-023 SHALL, on the synchronised spirdt rising edge, register spirddata from a mux: addresses 0-7 give the ctrl register, 8-14 give the status byte, 15 gives IDVALUE; it SHALL also pulse rdstb for one cycle and set evaddr = spiaddr.
REQ-024 SHALL hold spirddata unchanged between spirdt rising edges, so the value is stable from rise + 4 clk until the slave loads it at SCLK count 8.
REQ-025 SHALL sample status only on the capture cycle, giving a coherent snapshot per read.
REQ-026 SHALL never assert wrstb and rdstb in the same cycle; should both edges occur in one cycle, wrstb wins and the read capture is deferred by 1 cycle.

Reset
REQ-027 SHALL, while reset is high, set ctrl = CTRLRESET, spirddata = 8'h00, wrstb = 0, rdstb = 0, evaddr = 0, edge counter = 0, and all synchronisers = 0.
REQ-028 SHALL, when reset is asserted mid-transaction, abandon that transaction; the first wrt falling edge after reset SHALL NOT commit, because the counter must first see a wrt rising edge.

Structure
REQ-029 SHALL place the synchroniser depths (2, 3), the required write edge count (8), and the address boundaries (7, 15) as constants in a shared spi package.
REQ-030 SHALL implement the synchroniser as the sub-module spisync (parameter DEPTH, 1-bit), instantiated three times.

Verification
REQ-031 SHALL verify: SPI write, mode 0, addr 3, data 8'h5C -> ctrl[31:24] = 8'h5C, one wrstb pulse, evaddr = 3.
REQ-032 SHALL verify: SPI read of addr 15 -> spirddata = 8'hA5, rdstb pulse, evaddr = 15, MISO shifts out 10100101.
REQ-033 SHALL verify: write aborted by deasserting SS after 5 data clocks to addr 1 -> ctrl unchanged, no wrstb.
REQ-034 SHALL verify: status[7:0] = 8'h11 and status changed to 8'h22 after the capture, read addr 8 -> MISO returns 8'h11.
REQ-035 SHALL verify: reset pulsed during the data phase of a write to addr 0 -> ctrl = CTRLRESET, no wrstb; the next full write of 8'hFF to addr 0 commits.
REQ-036 SHALL verify: back-to-back write addr 2 = 8'h01 then read addr 2 at clk = 4 x SCLK -> read returns 8'h01.

Source files
------------

// File: rtl/spi_regfile_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | spi_regfile_pkg : shared constants, types and read mux for spi_regfile |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
package spi_regfile_pkg;

  localparam int         SYNC_SCLK_DEPTH  = 2;
  localparam int         SYNC_CMD_DEPTH   = 3;
  localparam logic [3:0] WR_EDGES         = 4'd8;
  localparam logic [3:0] EDGE_MAX         = 4'd15;
  localparam logic [3:0] CTRL_ADDR_MAX    = 4'd7;
  localparam logic [3:0] ID_ADDR          = 4'd15;

  typedef struct packed {
    logic sclk_rise;
    logic wrt_rise;
    logic wrt_fall;
    logic rdt_rise;
  } spi_edges_t;

  // Status addresses 8..14 map to status bytes 0..6, so addr[2:0] is the byte index.
  function automatic logic [7:0] rd_mux(input logic [3:0]  addr,
                                        input logic [63:0] ctrl,
                                        input logic [55:0] status,
                                        input logic [7:0]  id);
    logic [7:0] r;
    r = id;
    if (addr <= CTRL_ADDR_MAX) begin
      r = ctrl[{addr[2:0], 3'b000} +: 8];
    end else if (addr != ID_ADDR) begin
      r = status[{addr[2:0], 3'b000} +: 8];
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_regfile_spisync.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | spisync : DEPTH-stage 1-bit synchroniser, synchronous reset to 0       |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
module spisync #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [DEPTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[DEPTH-2:0], d_i};
    end
  end

  assign q_o = sync_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/spi_regfile.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | spi_regfile : clk-domain register file behind an asynchronous SPI slave|
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
module spi_regfile
  import spi_regfile_pkg::*;
#(
  parameter logic [7:0]  IDVALUE   = 8'hA5,
  parameter logic [63:0] CTRLRESET = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        spiclk,
  input  logic        spiwrt,
  input  logic        spirdt,
  input  logic [3:0]  spiaddr,
  input  logic [7:0]  spiwrtdata,
  output logic [7:0]  spirddata,
  output logic [63:0] ctrl,
  input  logic [55:0] status,
  output logic        wrstb,
  output logic        rdstb,
  output logic [3:0]  evaddr
);

  localparam logic [2:0] SETTLE_DONE = 3'(SYNC_CMD_DEPTH + 1);

  logic        sclk_s, wrt_s, rdt_s;
  logic        sclk_prev_q, wrt_prev_q, rdt_prev_q;
  logic [2:0]  settle_q;
  logic        live;
  spi_edges_t  ev;

  logic [3:0]  cnt_q, cnt_d;
  logic        armed_q, armed_d;
  logic [63:0] ctrl_q, ctrl_d;
  logic [7:0]  rddata_q, rddata_d;
  logic        wrstb_q, wrstb_d;
  logic        rdstb_q, rdstb_d;
  logic [3:0]  evaddr_q, evaddr_d;
  logic        rdpend_q, rdpend_d;

  spisync #(.DEPTH(SYNC_SCLK_DEPTH)) u_sync_sclk (.clk(clk), .reset(reset), .d_i(spiclk), .q_o(sclk_s));
  spisync #(.DEPTH(SYNC_CMD_DEPTH))  u_sync_wrt  (.clk(clk), .reset(reset), .d_i(spiwrt), .q_o(wrt_s));
  spisync #(.DEPTH(SYNC_CMD_DEPTH))  u_sync_rdt  (.clk(clk), .reset(reset), .d_i(spirdt), .q_o(rdt_s));

  // Edges are blanked until the zero-reset synchronisers have refilled, so a
  // line held high across reset is not mistaken for a fresh rising edge.
  assign live         = (settle_q == SETTLE_DONE);
  assign ev.sclk_rise = live & sclk_s & ~sclk_prev_q;
  assign ev.wrt_rise  = live & wrt_s  & ~wrt_prev_q;
  assign ev.wrt_fall  = live & ~wrt_s & wrt_prev_q;
  assign ev.rdt_rise  = live & rdt_s  & ~rdt_prev_q;

  always_comb begin
    cnt_d    = cnt_q;
    armed_d  = armed_q;
    ctrl_d   = ctrl_q;
    rddata_d = rddata_q;
    wrstb_d  = 1'b0;
    rdstb_d  = 1'b0;
    evaddr_d = evaddr_q;
    rdpend_d = 1'b0;

    if (ev.wrt_rise) begin
      cnt_d   = 4'd0;
      armed_d = 1'b1;
    end else if (ev.sclk_rise && wrt_s && armed_q && (cnt_q != EDGE_MAX)) begin
      cnt_d = cnt_q + 4'd1;
    end

    if (ev.wrt_fall) begin
      armed_d = 1'b0;
      if (armed_q && (cnt_q == WR_EDGES)) begin
        wrstb_d  = 1'b1;
        evaddr_d = spiaddr;
        if (spiaddr <= CTRL_ADDR_MAX) begin
          ctrl_d[{spiaddr[2:0], 3'b000} +: 8] = spiwrtdata;
        end
      end
    end

    // A read colliding with a commit waits one cycle and then sees the new value.
    if (ev.rdt_rise || rdpend_q) begin
      if (wrstb_d) begin
        rdpend_d = 1'b1;
      end else begin
        rdstb_d  = 1'b1;
        evaddr_d = spiaddr;
        rddata_d = rd_mux(spiaddr, ctrl_q, status, IDVALUE);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_prev_q <= 1'b0;
      wrt_prev_q  <= 1'b0;
      rdt_prev_q  <= 1'b0;
      settle_q    <= 3'd0;
      cnt_q       <= 4'd0;
      armed_q     <= 1'b0;
      ctrl_q      <= CTRLRESET;
      rddata_q    <= 8'h00;
      wrstb_q     <= 1'b0;
      rdstb_q     <= 1'b0;
      evaddr_q    <= 4'd0;
      rdpend_q    <= 1'b0;
    end else begin
      sclk_prev_q <= sclk_s;
      wrt_prev_q  <= wrt_s;
      rdt_prev_q  <= rdt_s;
      if (!live) begin
        settle_q <= settle_q + 3'd1;
      end
      cnt_q    <= cnt_d;
      armed_q  <= armed_d;
      ctrl_q   <= ctrl_d;
      rddata_q <= rddata_d;
      wrstb_q  <= wrstb_d;
      rdstb_q  <= rdstb_d;
      evaddr_q <= evaddr_d;
      rdpend_q <= rdpend_d;
    end
  end

  assign spirddata = rddata_q;
  assign ctrl      = ctrl_q;
  assign wrstb     = wrstb_q;
  assign rdstb     = rdstb_q;
  assign evaddr    = evaddr_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_regfile.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_spi_regfile : scoreboard bench driving SPI-slave-side handshakes    |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
module tb_spi_regfile;

  localparam logic [63:0] C_CTRL_RST = 64'h8877665544332211;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        spiclk = 1'b0;
  logic        spiwrt = 1'b0;
  logic        spirdt = 1'b0;
  logic [3:0]  spiaddr = 4'd0;
  logic [7:0]  spiwrtdata = 8'h00;
  logic [55:0] status = 56'h0;
  logic [7:0]  spirddata;
  logic [63:0] ctrl;
  logic        wrstb, rdstb;
  logic [3:0]  evaddr;

  typedef struct packed {
    logic        is_rd;
    logic [3:0]  addr;
    logic [63:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] exp_ctrl = C_CTRL_RST;
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  spi_regfile #(.IDVALUE(8'hA5), .CTRLRESET(C_CTRL_RST)) dut (
    .clk(clk), .reset(reset), .spiclk(spiclk), .spiwrt(spiwrt), .spirdt(spirdt),
    .spiaddr(spiaddr), .spiwrtdata(spiwrtdata), .spirddata(spirddata), .ctrl(ctrl),
    .status(status), .wrstb(wrstb), .rdstb(rdstb), .evaddr(evaddr)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
  endtask

  task automatic sclk_pulse(input int half);
    spiclk = 1'b1; #(half);
    spiclk = 1'b0; #(half);
  endtask

  task automatic spi_wr(input logic [3:0] a, input logic [7:0] d, input int nclk,
                        input int half, input bit commits);
    exp_t e;
    if (commits) begin
      if (a <= 4'd7) exp_ctrl[int'(a)*8 +: 8] = d;
      e.is_rd = 1'b0; e.addr = a; e.data = exp_ctrl;
      sb.push_back(e);
    end
    spiaddr = a; spiwrtdata = d; spiwrt = 1'b1; #(half);
    repeat (nclk) sclk_pulse(half);
    spiwrt = 1'b0; #(4*half);
  endtask

  // Slave model: parallel-load at SCLK count 8, then shift MSB first.
  task automatic spi_rd(input logic [3:0] a, input logic [7:0] expv, input int half);
    exp_t e;
    logic [7:0] sh, got;
    sh = 8'h00; got = 8'h00;
    e.is_rd = 1'b1; e.addr = a; e.data = {56'h0, expv};
    sb.push_back(e);
    spiaddr = a; spirdt = 1'b1; #(half);
    for (int i = 1; i <= 8; i++) begin
      spiclk = 1'b1;
      if (i == 8) sh = spirddata;
      #(half); spiclk = 1'b0; #(half);
    end
    for (int i = 0; i < 8; i++) begin
      spiclk = 1'b1; got = {got[6:0], sh[7]};
      #(half); spiclk = 1'b0; sh = {sh[6:0], 1'b0}; #(half);
    end
    spirdt = 1'b0; #(4*half);
    chk("miso_byte", {56'h0, got}, {56'h0, expv});
  endtask

  // Monitor: every strobe must match the oldest expected event.
  always @(negedge clk) begin
    if (!reset && (wrstb || rdstb)) begin
      chk("strobe_exclusive", {63'h0, wrstb & rdstb}, 64'h0);
      if (sb.size() == 0) begin
        chk("unexpected_strobe", {62'h0, wrstb, rdstb}, 64'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("event_kind", {63'h0, rdstb}, {63'h0, e.is_rd});
        chk("evaddr", {60'h0, evaddr}, {60'h0, e.addr});
        if (e.is_rd) chk("rd_data", {56'h0, spirddata}, {56'h0, e.data[7:0]});
        else         chk("wr_ctrl", ctrl, e.data);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    status = 56'hDE_AD_BE_EF_12_34_11;
    repeat (4) @(posedge clk);
    #2;
    chk("rst_ctrl", ctrl, C_CTRL_RST);
    chk("rst_rddata", {56'h0, spirddata}, 64'h0);
    chk("rst_wrstb", {63'h0, wrstb}, 64'h0);
    chk("rst_rdstb", {63'h0, rdstb}, 64'h0);
    chk("rst_evaddr", {60'h0, evaddr}, 64'h0);
    reset = 1'b0;
    #100;

    spi_wr(4'd3, 8'h5C, 8, 40, 1'b1);
    chk("ctrl_after_wr3", ctrl, 64'h8877_6655_5C33_2211);
    spi_rd(4'd15, 8'hA5, 40);

    spi_wr(4'd1, 8'hC3, 5, 40, 1'b0);
    chk("ctrl_after_abort", ctrl, exp_ctrl);
    spi_wr(4'd4, 8'h99, 9, 40, 1'b0);
    chk("ctrl_after_overrun", ctrl, exp_ctrl);
    spi_wr(4'd12, 8'h77, 8, 40, 1'b1);
    chk("ctrl_after_wr12", ctrl, exp_ctrl);

    fork
      spi_rd(4'd8, 8'h11, 40);
      begin #120; status[7:0] = 8'h22; end
    join
    spi_rd(4'd14, 8'hDE, 40);
    spi_rd(4'd7, 8'h88, 40);

    // Reset in the middle of a write's data phase.
    spiaddr = 4'd0; spiwrtdata = 8'h3C; spiwrt = 1'b1; #40;
    repeat (4) sclk_pulse(40);
    reset = 1'b1; #30; reset = 1'b0;
    repeat (4) sclk_pulse(40);
    spiwrt = 1'b0; #160;
    exp_ctrl = C_CTRL_RST;
    chk("ctrl_after_midreset", ctrl, C_CTRL_RST);
    spi_wr(4'd0, 8'hFF, 8, 40, 1'b1);
    chk("ctrl_after_wr0", ctrl, 64'h8877_6655_4433_22FF);

    spi_wr(4'd2, 8'h01, 8, 20, 1'b1);
    spi_rd(4'd2, 8'h01, 20);
    spi_rd(4'd0, 8'hFF, 20);

    #200;
    chk("scoreboard_empty", 64'(sb.size()), 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
